// File: rtl/ins_mem_loader.sv
// Instruction memory loader: assembles little-endian host bytes into instruction words and
// holds the core in reset while loading. Optional opcode screening via INS_LOADER_OPCODE_CHECK_EN.
module ins_mem_loader #(
    parameter int INS_ADDR_WIDTH = 10,
    parameter int ADDR_WIDTH     = 10,
    parameter int OPCODE_WIDTH   = 3,
    localparam int INS_W         = OPCODE_WIDTH + 3 * ADDR_WIDTH,
    localparam int BYTES_PER_INS = (INS_W + 7) / 8
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic [7:0]                s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic [INS_ADDR_WIDTH-1:0] ins_waddr,
    output logic [INS_W-1:0]          ins_wdata,
    output logic                      ins_we,
    output logic                      core_rstn,
    output logic                      busy,
    output logic                      done,
    output logic                      count_err
`ifdef INS_LOADER_OPCODE_CHECK_EN
    ,
    output logic                      opcode_err
`endif
);

    localparam int WORD_BITS = BYTES_PER_INS * 8;
    localparam int BC_W      = $clog2(BYTES_PER_INS + 1);
    localparam int CNT_W     = INS_ADDR_WIDTH + 1;
    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BYTES_PER_INS - 1);
    localparam logic [16:0]     MAX_N     = 17'(2 ** INS_ADDR_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        PAYLOAD,
        WRITE,
        DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [BC_W-1:0]           byte_cnt_q, byte_cnt_d;
    logic [WORD_BITS-1:0]      word_q, word_d;
    logic [7:0]                cnt_lo_q, cnt_lo_d;
    logic [CNT_W-1:0]          words_left_q, words_left_d;
    logic [INS_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic                      s_ready_q, s_ready_d;
    logic [INS_ADDR_WIDTH-1:0] ins_waddr_q, ins_waddr_d;
    logic [INS_W-1:0]          ins_wdata_q, ins_wdata_d;
    logic                      ins_we_q, ins_we_d;
    logic                      core_rstn_q, core_rstn_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      count_err_q, count_err_d;
    logic                      opcode_err_q, opcode_err_d;

    logic                      xfer;
    logic [WORD_BITS-1:0]      next_word;
    logic [15:0]               header_n;

    assign xfer      = s_valid && s_ready_q;
    assign next_word = {s_data, word_q[WORD_BITS-1:8]};
    assign header_n  = {s_data, cnt_lo_q};

`ifdef INS_LOADER_OPCODE_CHECK_EN
    localparam logic [OPCODE_WIDTH-1:0] OPCODE_MAX = OPCODE_WIDTH'(5);
    logic opcode_bad;
    assign opcode_bad = next_word[INS_W-1 -: OPCODE_WIDTH] > OPCODE_MAX;
    assign opcode_err = opcode_err_q;
`endif

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        word_d       = word_q;
        cnt_lo_d     = cnt_lo_q;
        words_left_d = words_left_q;
        wr_ptr_d     = wr_ptr_q;
        ins_waddr_d  = ins_waddr_q;
        ins_wdata_d  = ins_wdata_q;
        ins_we_d     = 1'b0;
        core_rstn_d  = core_rstn_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        count_err_d  = count_err_q;
        opcode_err_d = opcode_err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = HDR0;
                    busy_d       = 1'b1;
                    core_rstn_d  = 1'b0;
                    count_err_d  = 1'b0;
                    opcode_err_d = 1'b0;
                    wr_ptr_d     = '0;
                    byte_cnt_d   = '0;
                end
            end
            HDR0: begin
                if (xfer) begin
                    cnt_lo_d = s_data;
                    state_d  = HDR1;
                end
            end
            HDR1: begin
                if (xfer) begin
                    if (header_n == 16'd0) begin
                        state_d = DONE;
                    end else if ({1'b0, header_n} > MAX_N) begin
                        // Oversized program: abandon without touching memory, core stays held
                        state_d     = IDLE;
                        count_err_d = 1'b1;
                        busy_d      = 1'b0;
                    end else begin
                        words_left_d = CNT_W'(header_n);
                        state_d      = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (xfer) begin
                    word_d = next_word;
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d  = '0;
                        state_d     = WRITE;
                        ins_waddr_d = wr_ptr_q;
                        ins_wdata_d = next_word[INS_W-1:0];
`ifdef INS_LOADER_OPCODE_CHECK_EN
                        ins_we_d = !opcode_bad;
                        if (opcode_bad) begin
                            opcode_err_d = 1'b1;
                        end
`else
                        ins_we_d = 1'b1;
`endif
                    end else begin
                        byte_cnt_d = byte_cnt_q + BC_W'(1);
                    end
                end
            end
            WRITE: begin
                words_left_d = words_left_q - CNT_W'(1);
                // Pointer stops on the last address so a full-size program never wraps it
                if (words_left_q == CNT_W'(1)) begin
                    state_d = DONE;
                end else begin
                    wr_ptr_d = wr_ptr_q + INS_ADDR_WIDTH'(1);
                    state_d  = PAYLOAD;
                end
            end
            DONE: begin
                state_d     = IDLE;
                busy_d      = 1'b0;
                done_d      = !opcode_err_q;
                core_rstn_d = !opcode_err_q;
            end
            default: state_d = IDLE;
        endcase

        s_ready_d = (state_d == HDR0) || (state_d == HDR1) || (state_d == PAYLOAD);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            byte_cnt_q   <= '0;
            word_q       <= '0;
            cnt_lo_q     <= '0;
            words_left_q <= '0;
            wr_ptr_q     <= '0;
            s_ready_q    <= 1'b0;
            ins_waddr_q  <= '0;
            ins_wdata_q  <= '0;
            ins_we_q     <= 1'b0;
            core_rstn_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            count_err_q  <= 1'b0;
            opcode_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            word_q       <= word_d;
            cnt_lo_q     <= cnt_lo_d;
            words_left_q <= words_left_d;
            wr_ptr_q     <= wr_ptr_d;
            s_ready_q    <= s_ready_d;
            ins_waddr_q  <= ins_waddr_d;
            ins_wdata_q  <= ins_wdata_d;
            ins_we_q     <= ins_we_d;
            core_rstn_q  <= core_rstn_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            count_err_q  <= count_err_d;
            opcode_err_q <= opcode_err_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign ins_waddr = ins_waddr_q;
    assign ins_wdata = ins_wdata_q;
    assign ins_we    = ins_we_q;
    assign core_rstn = core_rstn_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign count_err = count_err_q;

endmodule

// File: tb/tb_ins_mem_loader.sv
// Self-checking bench for ins_mem_loader: directed loads plus randomized byte streams compared
// against a reference memory image built from the program word list.
module tb_ins_mem_loader;

    localparam int INS_ADDR_WIDTH = 10;
    localparam int INS_W          = 33;

    logic                      clk = 1'b0;
    logic                      rstn = 1'b0;
    logic                      start = 1'b0;
    logic [7:0]                s_data = 8'h00;
    logic                      s_valid = 1'b0;
    logic                      s_ready;
    logic [INS_ADDR_WIDTH-1:0] ins_waddr;
    logic [INS_W-1:0]          ins_wdata;
    logic                      ins_we;
    logic                      core_rstn;
    logic                      busy;
    logic                      done;
    logic                      count_err;
`ifdef INS_LOADER_OPCODE_CHECK_EN
    logic                      opcode_err;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    logic [INS_W-1:0]          words[$];
    logic [INS_W-1:0]          obs_data[$];
    logic [INS_ADDR_WIDTH-1:0] obs_addr[$];
    int                        done_seen = 0;

    ins_mem_loader dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .ins_waddr (ins_waddr),
        .ins_wdata (ins_wdata),
        .ins_we    (ins_we),
        .core_rstn (core_rstn),
        .busy      (busy),
        .done      (done),
        .count_err (count_err)
`ifdef INS_LOADER_OPCODE_CHECK_EN
        ,
        .opcode_err(opcode_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Write/done monitor; every write cycle must also block the host link
    always @(negedge clk) begin
        if (rstn && ins_we === 1'b1) begin
            obs_addr.push_back(ins_waddr);
            obs_data.push_back(ins_wdata);
            checkOutput("s_ready_in_write", s_ready, 0);
        end
        if (rstn && done === 1'b1) done_seen++;
    end

    task automatic clearObs();
        obs_addr.delete();
        obs_data.delete();
        done_seen = 0;
    endtask

    task automatic genWords(input int n);
        words.delete();
        for (int i = 0; i < n; i++)
            words.push_back({3'($urandom_range(0, 5)), 30'($urandom)});
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap, input bit mid_start);
        int waited = 0;
        while ($urandom_range(0, 99) < gap) begin
            s_valid = 1'b0;
            s_data  = 8'($urandom);
            @(negedge clk);
        end
        s_data  = b;
        s_valid = 1'b1;
        start   = mid_start;
        while (s_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            start = 1'b0;
            waited++;
        end
        if (waited >= 200) checkOutput("ready_timeout", s_ready, 1);
        @(negedge clk);
        start   = 1'b0;
        s_valid = 1'b0;
    endtask

    task automatic applyStimulus(input int n, input int gap, input bit mid, input int nbytes,
                                 input bit chk_lat);
        logic [39:0] wide = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("start_busy", busy, 1);
        checkOutput("start_core_rstn", core_rstn, 0);
        checkOutput("start_clears_count_err", count_err, 0);
        sendByte(n[7:0], gap, 1'b0);
        sendByte(n[15:8], gap, 1'b0);
        for (int i = 0; i < nbytes; i++) begin
            if (i % 5 == 0) wide = {7'($urandom), words[i / 5]};
            sendByte(wide[8 * (i % 5) +: 8], gap, mid && ($urandom_range(0, 9) == 0));
            if (chk_lat && (i % 5 == 4)) begin
                checkOutput("we_latency", ins_we, 1);
                checkOutput("we_addr", ins_waddr, i / 5);
            end
        end
    endtask

    task automatic waitIdle();
        int cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 100) checkOutput("idle_timeout", busy, 0);
        @(negedge clk);
        @(negedge clk);
    endtask

    // Reference: a legal count N writes words[0..N-1] to addresses 0..N-1, then releases the core
    task automatic checkLoad(input string tag, input int n);
        bit accepted;
        int exp_writes;
        accepted   = (n <= (1 << INS_ADDR_WIDTH));
        exp_writes = accepted ? n : 0;
        checkOutput({tag, "_nwrites"}, obs_data.size(), exp_writes);
        for (int i = 0; i < exp_writes && i < obs_data.size(); i++) begin
            checkOutput({tag, "_addr"}, obs_addr[i], i);
            checkOutput({tag, "_data"}, obs_data[i], words[i]);
        end
        checkOutput({tag, "_done_pulses"}, done_seen, accepted);
        checkOutput({tag, "_core_rstn"}, core_rstn, accepted);
        checkOutput({tag, "_count_err"}, count_err, !accepted);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_s_ready"}, s_ready, 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_s_ready"}, s_ready, 0);
        checkOutput({tag, "_ins_waddr"}, ins_waddr, 0);
        checkOutput({tag, "_ins_wdata"}, ins_wdata, 0);
        checkOutput({tag, "_ins_we"}, ins_we, 0);
        checkOutput({tag, "_core_rstn"}, core_rstn, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_count_err"}, count_err, 0);
    endtask

    initial begin
        $display("[TB] ins_mem_loader bench starting");
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rstn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkAllZero("after_reset");

        // Two known words
        clearObs();
        words.delete();
        words.push_back(33'h0_0040_0801);
        words.push_back(33'h1_2345_6789);
        applyStimulus(2, 0, 1'b0, 10, 1'b1);
        waitIdle();
        checkLoad("known2", 2);

        // Oversized header rejected
        clearObs();
        words.delete();
        applyStimulus(16'h0401, 0, 1'b0, 0, 1'b0);
        waitIdle();
        checkLoad("count_err", 16'h0401);

        // Empty program: done two cycles after the last header byte
        clearObs();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("n0_count_err_cleared", count_err, 0);
        sendByte(8'h00, 0, 1'b0);
        sendByte(8'h00, 0, 1'b0);
        checkOutput("n0_done_early", done, 0);
        @(negedge clk);
        checkOutput("n0_done_timing", done, 1);
        checkOutput("n0_core_rstn_timing", core_rstn, 1);
        waitIdle();
        checkLoad("n0", 0);

        // Random gaps and ignored mid-load starts
        clearObs();
        genWords(16);
        applyStimulus(16, 30, 1'b1, 80, 1'b1);
        waitIdle();
        checkLoad("rand16", 16);

        // Largest legal program
        clearObs();
        genWords(1 << INS_ADDR_WIDTH);
        applyStimulus(1 << INS_ADDR_WIDTH, 0, 1'b0, 5 << INS_ADDR_WIDTH, 1'b1);
        waitIdle();
        checkLoad("full", 1 << INS_ADDR_WIDTH);

        // Asynchronous reset three bytes into word 5
        clearObs();
        genWords(8);
        applyStimulus(8, 0, 1'b0, 28, 1'b1);
        rstn = 1'b0;
        #1;
        checkAllZero("mid_reset");
        checkOutput("mid_reset_nwrites", obs_data.size(), 5);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        clearObs();
        genWords(3);
        applyStimulus(3, 10, 1'b0, 15, 1'b1);
        waitIdle();
        checkLoad("reload", 3);

`ifdef INS_LOADER_OPCODE_CHECK_EN
        clearObs();
        words.delete();
        words.push_back(33'h0_0000_0001);
        words.push_back({3'b111, 30'h0000_0005});
        words.push_back(33'h1_0000_0003);
        applyStimulus(3, 0, 1'b0, 15, 1'b0);
        waitIdle();
        checkOutput("opc_nwrites", obs_data.size(), 2);
        if (obs_data.size() == 2) begin
            checkOutput("opc_addr0", obs_addr[0], 0);
            checkOutput("opc_addr1", obs_addr[1], 2);
            checkOutput("opc_data1", obs_data[1], words[2]);
        end
        checkOutput("opc_err", opcode_err, 1);
        checkOutput("opc_done_pulses", done_seen, 0);
        checkOutput("opc_core_rstn", core_rstn, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
